switch_nport: RTL and testbench

//  Parametrised N-port packet switch; successor to the fixed 4-port switch.

---
 rtl/switch_nport.sv | 165 ++++++++++++++++
 tb/tb_switch_nport.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_nport.sv
`default_nettype none
// ============================================================================
// switch_nport : N-port packet switch, per-input FIFOs, per-output RR arbiters
// Revision     : 1.0
// ============================================================================
module switch_nport #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            i_in_valid,
  output logic [NUM_PORTS-1:0]            o_in_ready,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]  i_in_source,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]  i_in_target,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_in_data,
  output logic [NUM_PORTS-1:0]            o_out_valid,
  input  logic [NUM_PORTS-1:0]            i_out_ready,
  output logic [NUM_PORTS*NUM_PORTS-1:0]  o_out_source,
  output logic [NUM_PORTS*NUM_PORTS-1:0]  o_out_target,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] o_out_data,
  output logic [NUM_PORTS-1:0]            o_drop_pulse
);

  localparam int c_PW = $clog2(NUM_PORTS);
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [DATA_WIDTH-1:0] r_mem_data [NUM_PORTS][FIFO_DEPTH];
  logic [NUM_PORTS-1:0]  r_mem_src  [NUM_PORTS][FIFO_DEPTH];
  logic [NUM_PORTS-1:0]  r_mem_tgt  [NUM_PORTS][FIFO_DEPTH];
  logic [c_AW-1:0]       r_wptr     [NUM_PORTS];
  logic [c_AW-1:0]       r_rptr     [NUM_PORTS];
  logic [c_CW-1:0]       r_count    [NUM_PORTS];
  logic [c_PW-1:0]       r_rr       [NUM_PORTS];

  logic [NUM_PORTS-1:0]            r_out_valid;
  logic [NUM_PORTS*NUM_PORTS-1:0]  r_out_src;
  logic [NUM_PORTS*NUM_PORTS-1:0]  r_out_tgt;
  logic [NUM_PORTS*DATA_WIDTH-1:0] r_out_data;
  logic [NUM_PORTS-1:0]            r_drop;

  logic [NUM_PORTS-1:0]  w_full;
  logic [NUM_PORTS-1:0]  w_empty;
  logic [NUM_PORTS-1:0]  w_tgt_ok;
  logic [NUM_PORTS-1:0]  w_accept;
  logic [NUM_PORTS-1:0]  w_push;
  logic [NUM_PORTS-1:0]  w_pop;
  logic [NUM_PORTS-1:0]  w_ld;
  logic [NUM_PORTS-1:0]  w_gnt_vld;
  logic [c_PW-1:0]       w_gnt_idx  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_head_data[NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_head_src [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_head_tgt [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
    logic [NUM_PORTS-1:0] w_tgt;
    assign w_tgt           = i_in_target[gi*NUM_PORTS +: NUM_PORTS];
    assign w_full[gi]      = (r_count[gi] == c_CW'(FIFO_DEPTH));
    assign w_empty[gi]     = (r_count[gi] == '0);
    // exactly one bit set: non-zero and clearing the lowest set bit leaves zero
    assign w_tgt_ok[gi]    = (w_tgt != '0) && ((w_tgt & (w_tgt - 1'b1)) == '0);
    assign o_in_ready[gi]  = rst_n & ~w_full[gi];
    assign w_accept[gi]    = i_in_valid[gi] & o_in_ready[gi];
    assign w_push[gi]      = w_accept[gi] & w_tgt_ok[gi];
    assign w_head_data[gi] = r_mem_data[gi][r_rptr[gi]];
    assign w_head_src[gi]  = r_mem_src[gi][r_rptr[gi]];
    assign w_head_tgt[gi]  = r_mem_tgt[gi][r_rptr[gi]];
  end

  for (genvar go = 0; go < NUM_PORTS; go++) begin : g_ld
    assign w_ld[go] = ~r_out_valid[go] | i_out_ready[go];
  end

  // Round-robin search per output, starting at the pointer and wrapping mod N.
  always_comb begin
    logic [c_PW:0] w_scan;
    w_scan    = '0;
    w_gnt_vld = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_gnt_idx[o] = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        w_scan = {1'b0, r_rr[o]} + (c_PW+1)'(k);
        if (w_scan >= (c_PW+1)'(NUM_PORTS)) begin
          w_scan = w_scan - (c_PW+1)'(NUM_PORTS);
        end
        if (w_ld[o] && !w_gnt_vld[o] && !w_empty[w_scan[c_PW-1:0]] &&
            w_head_tgt[w_scan[c_PW-1:0]][o]) begin
          w_gnt_vld[o] = 1'b1;
          w_gnt_idx[o] = w_scan[c_PW-1:0];
        end
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (w_gnt_vld[o]) begin
        w_pop[w_gnt_idx[o]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_push[i]) begin
        r_mem_data[i][r_wptr[i]] <= i_in_data[i*DATA_WIDTH +: DATA_WIDTH];
        r_mem_src[i][r_wptr[i]]  <= i_in_source[i*NUM_PORTS +: NUM_PORTS];
        r_mem_tgt[i][r_wptr[i]]  <= i_in_target[i*NUM_PORTS +: NUM_PORTS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
        r_rr[i]    <= '0;
      end
      r_out_valid <= '0;
      r_out_src   <= '0;
      r_out_tgt   <= '0;
      r_out_data  <= '0;
      r_drop      <= '0;
    end else begin
      r_drop <= w_accept & ~w_tgt_ok;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + 1'b1;
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + 1'b1;
        end
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + 1'b1;
          2'b01:   r_count[i] <= r_count[i] - 1'b1;
          default: r_count[i] <= r_count[i];
        endcase
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_gnt_vld[o]) begin
          r_out_valid[o]                           <= 1'b1;
          r_out_data[o*DATA_WIDTH +: DATA_WIDTH]   <= w_head_data[w_gnt_idx[o]];
          r_out_src[o*NUM_PORTS +: NUM_PORTS]      <= w_head_src[w_gnt_idx[o]];
          r_out_tgt[o*NUM_PORTS +: NUM_PORTS]      <= w_head_tgt[w_gnt_idx[o]];
          r_rr[o] <= (w_gnt_idx[o] == c_PW'(NUM_PORTS-1)) ? '0 : w_gnt_idx[o] + 1'b1;
        end else if (w_ld[o]) begin
          r_out_valid[o] <= 1'b0;
        end
      end
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_source = r_out_src;
  assign o_out_target = r_out_tgt;
  assign o_out_data   = r_out_data;
  assign o_drop_pulse = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_switch_nport.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_switch_nport : directed + random scoreboard bench for switch_nport
// Revision        : 1.0
// ============================================================================
module tb_switch_nport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic mode8 = 1'b0;
  int   np    = 4;
  int   checks = 0;
  int   errors = 0;
  int   delivered = 0;

  logic [7:0] d_valid  = 8'h00;
  logic [7:0] d_oready = 8'hFF;
  logic [7:0] d_src  [8];
  logic [7:0] d_tgt  [8];
  logic [7:0] d_data [8];

  logic [3:0]  a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_drop;
  logic [15:0] a_in_src, a_in_tgt, a_out_src, a_out_tgt;
  logic [31:0] a_in_data, a_out_data;
  logic [7:0]  b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_drop;
  logic [63:0] b_in_src, b_in_tgt, b_out_src, b_out_tgt;
  logic [63:0] b_in_data, b_out_data;

  switch_nport #(.NUM_PORTS(4), .DATA_WIDTH(8), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
    .i_in_source(a_in_src), .i_in_target(a_in_tgt), .i_in_data(a_in_data),
    .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
    .o_out_source(a_out_src), .o_out_target(a_out_tgt), .o_out_data(a_out_data),
    .o_drop_pulse(a_drop)
  );

  switch_nport #(.NUM_PORTS(8), .DATA_WIDTH(8), .FIFO_DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_in_source(b_in_src), .i_in_target(b_in_tgt), .i_in_data(b_in_data),
    .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
    .o_out_source(b_out_src), .o_out_target(b_out_tgt), .o_out_data(b_out_data),
    .o_drop_pulse(b_drop)
  );

  // Stimulus goes only to the active instance; the other idles with sinks ready.
  always_comb begin
    a_in_valid  = mode8 ? 4'h0 : d_valid[3:0];
    a_out_ready = mode8 ? 4'hF : d_oready[3:0];
    b_in_valid  = mode8 ? d_valid : 8'h00;
    b_out_ready = mode8 ? d_oready : 8'hFF;
    a_in_src = '0; a_in_tgt = '0; a_in_data = '0;
    b_in_src = '0; b_in_tgt = '0; b_in_data = '0;
    for (int i = 0; i < 4; i++) begin
      a_in_src[i*4 +: 4]  = d_src[i][3:0];
      a_in_tgt[i*4 +: 4]  = d_tgt[i][3:0];
      a_in_data[i*8 +: 8] = d_data[i];
    end
    for (int i = 0; i < 8; i++) begin
      b_in_src[i*8 +: 8]  = d_src[i];
      b_in_tgt[i*8 +: 8]  = d_tgt[i];
      b_in_data[i*8 +: 8] = d_data[i];
    end
  end

  logic [7:0] v_in_ready, v_out_valid, v_drop;
  logic [7:0] v_src [8];
  logic [7:0] v_tgt [8];
  logic [7:0] v_data[8];
  always_comb begin
    v_in_ready  = mode8 ? b_in_ready  : {4'h0, a_in_ready};
    v_out_valid = mode8 ? b_out_valid : {4'h0, a_out_valid};
    v_drop      = mode8 ? b_drop      : {4'h0, a_drop};
    for (int i = 0; i < 8; i++) begin
      v_src[i]  = mode8 ? b_out_src[i*8 +: 8]  : 8'h00;
      v_tgt[i]  = mode8 ? b_out_tgt[i*8 +: 8]  : 8'h00;
      v_data[i] = mode8 ? b_out_data[i*8 +: 8] : 8'h00;
    end
    if (!mode8) begin
      for (int i = 0; i < 4; i++) begin
        v_src[i]  = {4'h0, a_out_src[i*4 +: 4]};
        v_tgt[i]  = {4'h0, a_out_tgt[i*4 +: 4]};
        v_data[i] = a_out_data[i*8 +: 8];
      end
    end
  end

  function automatic int bit_idx(input logic [7:0] v);
    int r;
    r = 0;
    for (int k = 0; k < 8; k++) if (v[k]) r = k;
    return r;
  endfunction

  // Reference model: one FIFO of payloads per (input, output) pair.
  logic [7:0] sbq [64][$];
  logic [7:0] drop_nxt = 8'h00;
  logic [7:0] drop_exp = 8'h00;

  always @(negedge clk) begin : acceptor
    logic [7:0] t;
    drop_nxt = 8'h00;
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) sbq[k].delete();
    end else begin
      for (int i = 0; i < np; i++) begin
        if (d_valid[i] && v_in_ready[i]) begin
          t = d_tgt[i] & 8'((1 << np) - 1);
          if ($countones(t) == 1) sbq[i*8 + bit_idx(t)].push_back(d_data[i]);
          else drop_nxt[i] = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) drop_exp <= drop_nxt;

  logic [7:0] hold_v = 8'h00;
  logic [7:0] hold_src [8];
  logic [7:0] hold_tgt [8];
  logic [7:0] hold_data[8];

  always @(negedge clk) begin : monitor
    logic [7:0] exp_d;
    int src_i;
    if (!rst_n) begin
      hold_v = 8'h00;
    end else begin
      checks++;
      if (v_drop !== drop_exp) begin
        errors++;
        $display("FAIL drop_pulse: got %b expected %b", v_drop, drop_exp);
      end
      for (int o = 0; o < np; o++) begin
        if (hold_v[o]) begin
          checks++;
          if (v_out_valid[o] !== 1'b1 || v_src[o] !== hold_src[o] ||
              v_tgt[o] !== hold_tgt[o] || v_data[o] !== hold_data[o]) begin
            errors++;
            $display("FAIL hold_stable out%0d: got v=%b d=%h expected v=1 d=%h",
                     o, v_out_valid[o], v_data[o], hold_data[o]);
          end
        end
        if (v_out_valid[o] && d_oready[o]) begin
          delivered++;
          checks++;
          if ($countones(v_src[o]) != 1 || v_tgt[o] !== 8'(1 << o)) begin
            errors++;
            $display("FAIL header out%0d: got src=%b tgt=%b expected one-hot src, tgt=%b",
                     o, v_src[o], v_tgt[o], 8'(1 << o));
          end else begin
            src_i = bit_idx(v_src[o]);
            if (sbq[src_i*8 + o].size() == 0) begin
              errors++;
              $display("FAIL unexpected out%0d: got data=%h from in%0d expected nothing",
                       o, v_data[o], src_i);
            end else begin
              exp_d = sbq[src_i*8 + o].pop_front();
              if (v_data[o] !== exp_d) begin
                errors++;
                $display("FAIL data in%0d->out%0d: got %h expected %h", src_i, o, v_data[o], exp_d);
              end
            end
          end
        end
        hold_v[o]    = v_out_valid[o] && !d_oready[o];
        hold_src[o]  = v_src[o];
        hold_tgt[o]  = v_tgt[o];
        hold_data[o] = v_data[o];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle();
    d_valid = 8'h00;
    for (int i = 0; i < 8; i++) begin
      d_src[i] = 8'h00; d_tgt[i] = 8'h00; d_data[i] = 8'h00;
    end
  endtask

  task automatic drive(input int i, input logic [7:0] tgt, input logic [7:0] data);
    d_valid[i] = 1'b1;
    d_src[i]   = 8'(1 << i);
    d_tgt[i]   = tgt;
    d_data[i]  = data;
  endtask

  function automatic int sb_left();
    int n;
    n = 0;
    for (int k = 0; k < 64; k++) n += sbq[k].size();
    return n;
  endfunction

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int next, dcnt, ov_seen, t;
    logic w;
    idle();

    // Reset with all inputs valid: nothing accepted, nothing delivered
    for (int i = 0; i < 4; i++) drive(i, 8'(1 << i), 8'h10 + 8'(i));
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("reset_in_ready", 32'(a_in_ready), 32'h0);
      chk("reset_out_valid", 32'(a_out_valid), 32'h0);
    end
    chk("reset_out_data", a_out_data, 32'h0);
    idle();
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 32'(a_in_ready), 32'hF);
    chk("reset_delivered", 32'(delivered), 32'h0);

    // Single packet latency
    drive(0, 8'b0100, 8'hA5);
    tick();
    idle();
    chk("single_not_early", 32'(a_out_valid), 32'h0);
    tick();
    chk("single_valid", 32'(a_out_valid), 32'b0100);
    chk("single_data", 32'(a_out_data[23:16]), 32'hA5);
    chk("single_src", 32'(a_out_src[11:8]), 32'b0001);
    tick();
    chk("single_gone", 32'(a_out_valid), 32'h0);

    // Full contention on output 1
    for (int i = 0; i < 4; i++) drive(i, 8'b0010, 8'h30 + 8'(i));
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("contend_valid", 32'(a_out_valid[1]), 32'h1);
      chk("contend_src", 32'(a_out_src[7:4]), 32'(1 << k));
    end
    tick();
    chk("contend_idle", 32'(a_out_valid), 32'h0);
    chk("contend_rr1", 32'(u_dut4.r_rr[1]), 32'h0);

    // Backpressure on output 3 from input 2
    d_oready = 8'b0111;
    next = 1;
    for (int c = 0; c < 12; c++) begin
      if (next <= 6) drive(2, 8'b1000, 8'(next)); else idle();
      w = d_valid[2] && a_in_ready[2];
      tick();
      if (w) next++;
    end
    idle();
    chk("bp_accepted", 32'(next - 1), 32'd5);
    chk("bp_in_ready", 32'(a_in_ready[2]), 32'h0);
    chk("bp_held_data", 32'(a_out_data[31:24]), 32'h01);
    d_oready = 8'hFF;
    for (int c = 0; c < 20 && next <= 6; c++) begin
      drive(2, 8'b1000, 8'(next));
      w = a_in_ready[2];
      tick();
      if (w) next++;
    end
    idle();
    chk("bp_sixth", 32'(next), 32'd7);
    t = 0;
    while (sbq[2*8 + 3].size() != 0 && t < 30) begin
      tick();
      t++;
    end
    tick();
    chk("bp_drained", 32'(sbq[2*8 + 3].size()), 32'h0);

    // Malformed targets
    dcnt = 0;
    ov_seen = 0;
    drive(3, 8'b0000, 8'hEE);
    tick();
    dcnt += int'(a_drop[3]);
    drive(3, 8'b0011, 8'hDD);
    tick();
    dcnt += int'(a_drop[3]);
    if (a_out_valid != 4'h0) ov_seen = 1;
    idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      dcnt += int'(a_drop[3]);
      if (a_out_valid != 4'h0) ov_seen = 1;
    end
    chk("malformed_drops", 32'(dcnt), 32'd2);
    chk("malformed_no_out", 32'(ov_seen), 32'h0);

    // Random regression on the 8-port, depth-8 instance
    rst_n = 1'b0;
    tick();
    mode8 = 1'b1;
    np = 8;
    tick();
    rst_n = 1'b1;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 8; i++) begin
        d_valid[i] = ($urandom_range(0, 99) < 55);
        d_src[i]   = 8'(1 << i);
        d_data[i]  = 8'($urandom);
        t = $urandom_range(0, 99);
        if (t < 6) d_tgt[i] = 8'h00;
        else if (t < 10) d_tgt[i] = 8'($urandom) | 8'h81;
        else if (t < 55) d_tgt[i] = 8'(1 << $urandom_range(0, 2));
        else d_tgt[i] = 8'(1 << $urandom_range(0, 7));
      end
      d_oready = 8'($urandom);
      tick();
    end
    idle();
    d_oready = 8'hFF;
    t = 0;
    while (sb_left() != 0 && t < 300) begin
      tick();
      t++;
    end
    tick();
    chk("random_no_loss", 32'(sb_left()), 32'h0);
    chk("random_activity", 32'(delivered > 500), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
